unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-ported, variable-latency memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage, loads/stores). Grants one transaction at a time, with data priority and bounded starvation for fetch. Returns read data with a one-cycle valid pulse and drives per-requester stall signals into the pipeline hazard logic. Includes an ack-timeout watchdog that reports an error.

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data width
MAX_IF_WAIT, 4, consecutive lost arbitrations after which IF wins the next arbitration
TIMEOUT, 255, cycles in BUSY without mem_ack before abort (1..65535)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch request (level)
if_addr  in  ADDR_W  fetch address, stable while if_req high
if_valid  out  1  one-cycle pulse, fetch complete
if_rdata  out  DATA_W  fetch data, valid with if_valid, held until next IF completion
if_stall  out  1  if_req & ~if_valid (combinational)
d_req  in  1  data request (level)
d_we  in  1  1 = store, 0 = load; stable while d_req high
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_valid  out  1  one-cycle pulse, data transaction complete
d_rdata  out  DATA_W  load data; 0 after a store or error
d_stall  out  1  d_req & ~d_valid (combinational)
err  out  1  one-cycle pulse coincident with x_valid when the transaction timed out
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset values: all outputs 0; state IDLE; wait and timeout counters 0. Takes effect on the next edge from any state. An in-flight transaction is abandoned: no valid pulse, and mem_req is low on the cycle after reset.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE transitions:
  - Arbitrate among sampled requests. Winner's address, we and wdata are latched into mem_* registers; mem_req=1 from the next cycle.
  - mem_we=0 for IF grants; mem_we=d_we for data grants.
  - No request: stay in IDLE.
- Arbitration priority:
  - Data wins if the IF loss count < MAX_IF_WAIT; otherwise IF wins.
  - The loss counter increments when if_req is high and data wins, saturates at MAX_IF_WAIT, and clears on any IF grant.
- BUSY_x transitions:
  - mem_ack high: capture mem_rdata (data stores capture 0). mem_req=0 next cycle; go to DONE.
  - Timeout counter reaches TIMEOUT with no ack: mem_req=0, rdata=0, err=1 with valid; go to DONE.
  - Timeout counter clears on entry to BUSY.
- DONE:
  - Owner's x_valid=1 for exactly this cycle, with x_rdata updated.
  - Requests sampled in DONE are ignored; go to IDLE.
  - A requester wanting back-to-back access keeps req high and presents the new address in the cycle after valid.
- Minimum transaction length, ack in first BUSY cycle: req at IDLE cycle t, mem_req t+1, ack t+1, valid t+2, next grant decision t+3.
- Stray inputs:
  - mem_ack in IDLE or DONE is ignored.
  - if_req or d_req dropping mid-BUSY does not cancel the transaction; the valid pulse still occurs.
- Outputs if_valid, d_valid, err, mem_* and x_rdata are registered. Only the stall signals are combinational.
- if_valid and d_valid are never high in the same cycle.

Test Plan:
1. Assert then release reset mid-stream → every output 0 the cycle after reset; wait and timeout counters cleared.
2. if_req=1, if_addr=0x10, ack 2 cycles after mem_req rises with mem_rdata=0xDEADBEEF → mem_req=1, mem_addr=0x10, mem_we=0 for 2 cycles; if_valid pulse one cycle after ack with if_rdata=0xDEADBEEF; if_stall high until that cycle.
3. if_req and d_req (store, addr 0x200, wdata 0x5) rise together → data granted first: mem_we=1, mem_wdata=0x5, d_valid with d_rdata=0. IF is granted at the following IDLE.
4. d_req held continuously with back-to-back loads and if_req held, MAX_IF_WAIT=4 → exactly 4 data transactions complete, then IF is granted; loss counter reads 0 afterwards.
5. TIMEOUT=8, d_req load with no mem_ack → mem_req high for 8 cycles then low; d_valid=1, err=1, d_rdata=0 on the DONE cycle. A late mem_ack afterwards causes no pulse.
6. reset asserted during BUSY_I → no if_valid, mem_req=0 next cycle; a fresh if_req after reset completes normally.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between instruction
// fetch and data access: data priority, bounded fetch starvation, ack watchdog.
module unified_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_IF_WAIT = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        o_dbg_state,
    output logic [15:0]       o_dbg_loss_cnt,
    output logic [15:0]       o_dbg_tmo_cnt
);

    // Handshake: x_req is a level held (with stable address/we/wdata) until the
    // one-cycle x_valid; mem_req is held until mem_ack or the watchdog fires.
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    localparam logic [15:0] MAX_L = 16'(MAX_IF_WAIT);
    localparam logic [15:0] TMO_L = 16'(TIMEOUT);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_ack;
    logic                w_timeout;
    logic [15:0]         w_tmo_inc;
    logic [DATA_W-1:0]   w_fin_data;

    logic [15:0]         r_loss_cnt;
    logic [15:0]         r_tmo_cnt;
    logic                r_if_valid;
    logic                r_d_valid;
    logic                r_err;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        w_tmo_inc    = r_tmo_cnt + 16'd1;
        case (r_state)
            IDLE: begin
                // Fetch only overrides data once it has lost MAX_IF_WAIT times in a row.
                if (d_req && (!if_req || (r_loss_cnt < MAX_L))) begin
                    w_grant_d    = 1'b1;
                    w_state_next = BUSY_D;
                end else if (if_req) begin
                    w_grant_i    = 1'b1;
                    w_state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = DONE;
                end else if (w_tmo_inc == TMO_L) begin
                    w_timeout    = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_fin_data = (w_timeout || r_mem_we) ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_loss_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;
            if (w_grant_i || w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_grant_d & d_we;
                r_mem_addr  <= w_grant_d ? d_addr : if_addr;
                r_mem_wdata <= w_grant_d ? d_wdata : '0;
                r_tmo_cnt   <= '0;
            end
            if (w_grant_i) begin
                r_loss_cnt <= '0;
            end else if (w_grant_d && if_req && (r_loss_cnt < MAX_L)) begin
                r_loss_cnt <= r_loss_cnt + 16'd1;
            end
            if (w_ack || w_timeout) begin
                r_mem_req <= 1'b0;
                r_tmo_cnt <= '0;
                r_err     <= w_timeout;
                if (r_state == BUSY_I) begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= w_fin_data;
                end else begin
                    r_d_valid <= 1'b1;
                    r_d_rdata <= w_fin_data;
                end
            end else if (r_state == BUSY_I || r_state == BUSY_D) begin
                r_tmo_cnt <= w_tmo_inc;
            end
        end
    end

    assign if_valid       = r_if_valid;
    assign if_rdata       = r_if_rdata;
    assign if_stall       = if_req & ~r_if_valid;
    assign d_valid        = r_d_valid;
    assign d_rdata        = r_d_rdata;
    assign d_stall        = d_req & ~r_d_valid;
    assign err            = r_err;
    assign mem_req        = r_mem_req;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign o_dbg_state    = r_state;
    assign o_dbg_loss_cnt = r_loss_cnt;
    assign o_dbg_tmo_cnt  = r_tmo_cnt;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: transaction-level reference model predicting grants,
// memory windows and completions from the arbitration and latency rules.
module tb_unified_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXW = 4;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          d_stall;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [1:0]    o_dbg_state;
    logic [15:0]   o_dbg_loss_cnt;
    logic [15:0]   o_dbg_tmo_cnt;

    unified_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_IF_WAIT(MAXW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .o_dbg_state(o_dbg_state), .o_dbg_loss_cnt(o_dbg_loss_cnt),
        .o_dbg_tmo_cnt(o_dbg_tmo_cnt)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    bit rst_prev = 1'b0;
    bit force_rst = 1'b0;

    // Stimulus knobs (percentages, per-mille for reset, k_lat < 0 means random)
    int          k_if_new = 0, k_d_new = 0, k_store = 0, k_drop = 0, k_stray = 25;
    int          k_rst = 0, k_lat = -1;
    bit          k_rdata_en = 1'b0;
    logic [31:0] k_rdata = '0;

    // Requester state
    bit if_pend = 1'b0, d_pend = 1'b0, if_drop = 1'b0, d_drop = 1'b0;
    int if_cool = 0, d_cool = 0;

    // Reference model: one transaction in flight, described by grant cycle and length
    bit          m_busy = 1'b0, m_to = 1'b0, m_we = 1'b0;
    int          m_owner = 0, m_grant = 0, m_mcyc = 0, m_done = 0, m_free = 0, m_loss = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ack_data = '0;
    logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d act=0x%0h exp=0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit          do_rst, win, ack_now, exp_iv, exp_dv, exp_er, in_busy;
        int          lat;
        logic [31:0] sb;
        do_rst  = force_rst || (k_rst > 0 && $urandom_range(0, 999) < k_rst);
        reset   = do_rst;
        in_busy = m_busy && cyc > m_grant && cyc <= m_grant + m_mcyc;

        if (if_cool > 0) begin
            if_cool--;
            if_req = 1'b0;
        end else if (!if_pend) begin
            if ($urandom_range(0, 99) < k_if_new) begin
                if_pend = 1'b1; if_drop = 1'b0; if_addr = $urandom; if_req = 1'b1;
            end else begin
                if_req = 1'b0;
            end
        end else if (in_busy && m_owner == 0 && !if_drop && $urandom_range(0, 99) < k_drop) begin
            if_drop = 1'b1; if_req = 1'b0;
        end else begin
            if_req = !if_drop;
        end

        if (d_cool > 0) begin
            d_cool--;
            d_req = 1'b0;
        end else if (!d_pend) begin
            if ($urandom_range(0, 99) < k_d_new) begin
                d_pend = 1'b1; d_drop = 1'b0; d_addr = $urandom; d_wdata = $urandom;
                d_we = ($urandom_range(0, 99) < k_store); d_req = 1'b1;
            end else begin
                d_req = 1'b0;
            end
        end else if (in_busy && m_owner == 1 && !d_drop && $urandom_range(0, 99) < k_drop) begin
            d_drop = 1'b1; d_req = 1'b0;
        end else begin
            d_req = !d_drop;
        end

        win       = in_busy;
        ack_now   = win && !m_to && cyc == m_grant + m_mcyc;
        mem_rdata = k_rdata_en ? k_rdata : $urandom;
        mem_ack   = ack_now || (!win && $urandom_range(0, 99) < k_stray);
        if (ack_now) m_ack_data = mem_rdata;
        #1;

        exp_iv = m_busy && m_owner == 0 && cyc == m_done;
        exp_dv = m_busy && m_owner == 1 && cyc == m_done;
        exp_er = (exp_iv || exp_dv) && m_to;
        if (exp_iv) begin
            exp_if_rdata = m_to ? 32'h0 : m_ack_data;
            exp_q.push_back(exp_if_rdata);
        end
        if (exp_dv) begin
            exp_d_rdata = (m_to || m_we) ? 32'h0 : m_ack_data;
            exp_q.push_back(exp_d_rdata);
        end

        if (check_en) begin
            check("mem_req", mem_req, win);
            if (win) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_we", mem_we, m_we);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end
            check("if_valid", if_valid, exp_iv);
            check("d_valid", d_valid, exp_dv);
            check("err", err, exp_er);
            check("if_rdata", if_rdata, exp_if_rdata);
            check("d_rdata", d_rdata, exp_d_rdata);
            check("if_stall", if_stall, if_req & ~exp_iv);
            check("d_stall", d_stall, d_req & ~exp_dv);
            check("loss_cnt", o_dbg_loss_cnt, m_loss);
            if (rst_prev) check("tmo_cnt_after_reset", o_dbg_tmo_cnt, 0);
            if (if_valid || d_valid) begin
                check("sb_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    sb = exp_q.pop_front();
                    check("sb_rdata", if_valid ? if_rdata : d_rdata, sb);
                end
            end
        end

        rst_prev = do_rst;
        if (m_busy && cyc == m_done) begin
            m_busy = 1'b0;
            m_free = cyc + 1;
            if (m_owner == 0) if_pend = 1'b0;
            else              d_pend  = 1'b0;
        end
        if (do_rst) begin
            m_busy = 1'b0; m_loss = 0; m_free = cyc + 1;
            exp_if_rdata = '0; exp_d_rdata = '0;
            exp_q.delete();
            if_pend = 1'b0; d_pend = 1'b0; if_cool = 1; d_cool = 1;
        end else if (!m_busy && cyc >= m_free && (if_req || d_req)) begin
            if (d_req && (!if_req || m_loss < MAXW)) begin
                m_owner = 1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                if (if_req) m_loss = (m_loss + 1 > MAXW) ? MAXW : m_loss + 1;
            end else begin
                m_owner = 0; m_addr = if_addr; m_we = 1'b0; m_loss = 0;
            end
            if (k_lat >= 0) lat = k_lat;
            else if ($urandom_range(0, 7) == 0) lat = $urandom_range(6, TMO + 2);
            else lat = $urandom_range(0, 3);
            m_to    = (lat >= TMO);
            m_mcyc  = m_to ? TMO : lat + 1;
            m_grant = cyc;
            m_done  = cyc + m_mcyc + 1;
            m_busy  = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step();
            @(posedge clk);
            cyc++;
            check_en = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

        force_rst = 1'b1;
        run(3);
        force_rst = 1'b0;
        run(4);

        // Single fetch, ack in the second memory cycle
        if_pend = 1'b1; if_drop = 1'b0; if_addr = 32'h10;
        k_lat = 1; k_rdata_en = 1'b1; k_rdata = 32'hDEADBEEF;
        run(6);
        k_rdata_en = 1'b0;

        // Fetch and store arrive together: store goes first
        if_pend = 1'b1; if_drop = 1'b0; if_addr = 32'h44;
        d_pend = 1'b1; d_drop = 1'b0; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h5;
        k_lat = 0;
        run(10);

        // Both requesters saturated with loads: fetch starvation bound
        k_if_new = 100; k_d_new = 100; k_store = 0;
        run(40);
        k_lat = -1;
        run(40);
        k_if_new = 0; k_d_new = 0;
        run(30);

        // Load with no ack: watchdog, then late acks
        d_pend = 1'b1; d_drop = 1'b0; d_we = 1'b0; d_addr = 32'h300;
        k_lat = TMO + 2; k_stray = 0;
        run(12);
        k_stray = 100;
        run(4);
        k_stray = 25;

        // Reset while a fetch is in flight, then fresh fetches
        if_pend = 1'b1; if_drop = 1'b0; if_addr = 32'h80; k_lat = 5;
        run(3);
        force_rst = 1'b1;
        run(1);
        force_rst = 1'b0; k_lat = -1; k_if_new = 100;
        run(15);
        k_if_new = 0;
        run(15);

        // Mixed random traffic with drops, stray acks and occasional resets
        k_if_new = 40; k_d_new = 40; k_store = 40; k_drop = 20; k_stray = 20; k_rst = 3;
        run(4000);
        k_if_new = 0; k_d_new = 0; k_rst = 0;
        run(40);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
